// File: rtl/serv_bus_arb.sv
// rtl/serv_bus_arb.sv - round-robin Wishbone arbiter sharing one master port between SERV ibus and dbus
module serv_bus_arb #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t               state;
    logic                 last_grant_d;   // 1 when dbus held the most recent grant
    logic                 ibus_done;
    logic                 dbus_done;
    logic [TIMEOUT_W-1:0] cnt;
    logic [31:0]          adr_q;
    logic [31:0]          dat_q;
    logic [3:0]           sel_q;
    logic                 we_q;

    logic ibus_elig;
    logic dbus_elig;
    logic pick_d;
    logic gnt_cyc;
    logic cnt_max;
    logic xfer_end;
    logic timeout;

    // Eligibility masks a requester whose cyc is still high after its ack
    assign ibus_elig = i_ibus_cyc & ~ibus_done;
    assign dbus_elig = i_dbus_cyc & ~dbus_done;

    // On a tie, the port that did not win last time gets the bus
    assign pick_d = dbus_elig & (~ibus_elig | ~last_grant_d);

    // Cyc of whichever port currently owns the bus; dropping it aborts at once
    assign gnt_cyc = (state == GNT_I) ? i_ibus_cyc :
                     (state == GNT_D) ? i_dbus_cyc : 1'b0;

    assign cnt_max  = &cnt;
    assign xfer_end = gnt_cyc & (i_wb_ack | cnt_max);
    assign timeout  = gnt_cyc & cnt_max & ~i_wb_ack;

    assign o_wb_cyc = gnt_cyc;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_err    = timeout;

    assign o_ibus_ack = (state == GNT_I) & xfer_end;
    assign o_dbus_ack = (state == GNT_D) & xfer_end;

    // A timed-out transfer returns zero data rather than whatever the bus floats
    assign o_ibus_rdt = ((state == GNT_I) && !timeout) ? i_wb_rdt : 32'h0;
    assign o_dbus_rdt = ((state == GNT_D) && !timeout) ? i_wb_rdt : 32'h0;

    // Grant FSM: latch the winner's request and hold it until ack, abort or timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            cnt          <= '0;
            adr_q        <= 32'h0;
            dat_q        <= 32'h0;
            sel_q        <= 4'h0;
            we_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state        <= GNT_D;
                        last_grant_d <= 1'b1;
                        cnt          <= '0;
                        adr_q        <= i_dbus_adr;
                        dat_q        <= i_dbus_dat;
                        sel_q        <= i_dbus_sel;
                        we_q         <= i_dbus_we;
                    end else if (ibus_elig) begin
                        state        <= GNT_I;
                        last_grant_d <= 1'b0;
                        cnt          <= '0;
                        adr_q        <= i_ibus_adr;
                        sel_q        <= 4'hF;
                        we_q         <= 1'b0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (!gnt_cyc || xfer_end) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Done flags: set by the port's ack, cleared whenever that port's cyc is low
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ibus_done <= 1'b0;
            dbus_done <= 1'b0;
        end else begin
            if (!i_ibus_cyc) begin
                ibus_done <= 1'b0;
            end else if (o_ibus_ack) begin
                ibus_done <= 1'b1;
            end
            if (!i_dbus_cyc) begin
                dbus_done <= 1'b0;
            end else if (o_dbus_ack) begin
                dbus_done <= 1'b1;
            end
        end
    end

endmodule
